// File: rtl/mem_stage_cache_pkg.sv
// Shared definitions for the MEM stage cache: branch condition codes,
// EX flag bit positions and cache controller state encodings.
package mem_stage_cache_pkg;

   typedef enum logic [2:0] {
      BNEQ    = 3'd0,
      BEQ     = 3'd1,
      BGT     = 3'd2,
      BLT     = 3'd3,
      BGTE    = 3'd4,
      BLTE    = 3'd5,
      BOVFL   = 3'd6,
      BUNCOND = 3'd7
   } branchOp_t;

   localparam int FLAG_N = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WB    = 2'd1,
      FILL  = 2'd2,
      FLUSH = 2'd3
   } cacheState_t;

endpackage

// File: rtl/mem_stage_cache_if.sv
// Backing-memory req/ack bus between the MEM stage cache (master) and the
// multi-cycle backing memory (slave).
interface mem_stage_cache_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic              bk_req;
   logic              bk_we;
   logic [ADDR_W-1:0] bk_addr;
   logic [DATA_W-1:0] bk_wdata;
   logic [DATA_W-1:0] bk_rdata;
   logic              bk_ack;

   modport master (
      output bk_req, bk_we, bk_addr, bk_wdata,
      input  bk_rdata, bk_ack
   );

   modport slave (
      input  bk_req, bk_we, bk_addr, bk_wdata,
      output bk_rdata, bk_ack
   );
endinterface

// File: rtl/mem_stage_cache_branch_resolve.sv
// Branch resolution: EX flags and branch condition code select pc_src.
module mem_stage_cache_branch_resolve
   import mem_stage_cache_pkg::*;
(
   input  logic [2:0] flags,
   input  logic [2:0] branch_op,
   input  logic       saw_br,
   input  logic       saw_j,
   output logic       pc_src
);

   logic cmp;

   always_comb begin
      cmp = 1'b0;
      case (branchOp_t'(branch_op))
         BNEQ:    cmp = !flags[FLAG_Z];
         BEQ:     cmp = flags[FLAG_Z];
         BGT:     cmp = !flags[FLAG_Z] && !flags[FLAG_N];
         BLT:     cmp = flags[FLAG_N];
         BGTE:    cmp = !flags[FLAG_N];
         BLTE:    cmp = flags[FLAG_N] || flags[FLAG_Z];
         BOVFL:   cmp = flags[FLAG_V];
         BUNCOND: cmp = 1'b1;
         default: cmp = 1'b0;
      endcase
   end

   assign pc_src = (saw_br & cmp) | saw_j;

endmodule

// File: rtl/mem_stage_cache.sv
// MEM stage: direct-mapped write-back data cache (single-word lines) over a
// req/ack backing memory, plus branch resolution. Optional MEM_STAGE_CACHE_FLUSH_EN
// adds a flush walk that writes back every dirty line.
//
// state | meaning
// IDLE  | serving hits / clean write-miss installs, no backing traffic
// WB    | writing the dirty victim back to backing memory
// FILL  | fetching the missed word from backing memory
// FLUSH | walking all lines, writing back dirty ones (flush build only)
module mem_stage_cache
   import mem_stage_cache_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int INDEX_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              mem_wr,
   input  logic              mem_rd,
   input  logic [2:0]        flags,
   input  logic [2:0]        branch_op,
   input  logic              saw_br,
   input  logic              saw_j,
`ifdef MEM_STAGE_CACHE_FLUSH_EN
   input  logic              flush,
   output logic              flush_done,
`endif
   output logic [DATA_W-1:0] rd_data,
   output logic              pc_src,
   output logic              stall,
   mem_stage_cache_if.master bk
);

   localparam int LINES = 2**INDEX_W;
   localparam int TAG_W = ADDR_W - INDEX_W;

   cacheState_t       state, stateNext;
   logic [TAG_W-1:0]  tagArr  [LINES];
   logic [DATA_W-1:0] dataArr [LINES];
   logic [LINES-1:0]  valid, dirty;

   logic [INDEX_W-1:0] idx;
   logic [TAG_W-1:0]   addrTag;
   logic               access, isRead, hit, victimDirty, bkDone;

   logic              bkReqQ, bkWeQ, bkReqNext, bkWeNext;
   logic [ADDR_W-1:0] bkAddrQ, bkAddrNext;
   logic [DATA_W-1:0] bkWdataQ, bkWdataNext;

   logic               lineWe, lineDirty, dirtyClr;
   logic [DATA_W-1:0]  lineData;
   logic [INDEX_W-1:0] dirtyClrIdx;

`ifdef MEM_STAGE_CACHE_FLUSH_EN
   logic [INDEX_W-1:0] walkIdx, walkIdxNext;
   logic               walkAdv, flushDoneQ, flushDoneNext;
   assign flush_done = flushDoneQ;
`endif

   assign idx         = mem_addr[INDEX_W-1:0];
   assign addrTag     = mem_addr[ADDR_W-1:INDEX_W];
   assign access      = mem_rd | mem_wr;
   assign isRead      = mem_rd & ~mem_wr;
   assign hit         = valid[idx] && (tagArr[idx] == addrTag);
   assign victimDirty = valid[idx] & dirty[idx];
   assign bkDone      = bkReqQ & bk.bk_ack;

   // Gated by rst_n so the pipeline sees no stall while reset is held.
   assign stall   = rst_n & ((state != IDLE) | (access & ~hit & (victimDirty | isRead)));
   assign rd_data = rst_n ? dataArr[idx] : '0;

   assign bk.bk_req   = bkReqQ;
   assign bk.bk_we    = bkWeQ;
   assign bk.bk_addr  = bkAddrQ;
   assign bk.bk_wdata = bkWdataQ;

   always_comb begin
      stateNext   = state;
      bkReqNext   = bkReqQ;
      bkWeNext    = bkWeQ;
      bkAddrNext  = bkAddrQ;
      bkWdataNext = bkWdataQ;
      lineWe      = 1'b0;
      lineData    = wr_data;
      lineDirty   = 1'b1;
      dirtyClr    = 1'b0;
      dirtyClrIdx = idx;
`ifdef MEM_STAGE_CACHE_FLUSH_EN
      walkIdxNext   = walkIdx;
      walkAdv       = 1'b0;
      flushDoneNext = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (access && !hit && victimDirty) begin
               stateNext   = WB;
               bkReqNext   = 1'b1;
               bkWeNext    = 1'b1;
               bkAddrNext  = {tagArr[idx], idx};
               bkWdataNext = dataArr[idx];
            end else if (access && !hit && isRead) begin
               stateNext  = FILL;
               bkReqNext  = 1'b1;
               bkWeNext   = 1'b0;
               bkAddrNext = mem_addr;
            end else if (mem_wr) begin
               lineWe = 1'b1;   // write hit, or install over a clean/invalid victim
            end
`ifdef MEM_STAGE_CACHE_FLUSH_EN
            else if (flush && !access) begin
               stateNext   = FLUSH;
               walkIdxNext = '0;
            end
`endif
         end
         WB: begin
            if (bkDone) begin
               dirtyClr  = 1'b1;
               bkReqNext = 1'b0;
               stateNext = IDLE;
               if (isRead) begin
                  stateNext  = FILL;
                  bkReqNext  = 1'b1;
                  bkWeNext   = 1'b0;
                  bkAddrNext = mem_addr;
               end
            end
         end
         FILL: begin
            if (bkDone) begin
               lineWe    = 1'b1;
               lineData  = bk.bk_rdata;
               lineDirty = 1'b0;
               bkReqNext = 1'b0;
               stateNext = IDLE;
            end
         end
`ifdef MEM_STAGE_CACHE_FLUSH_EN
         FLUSH: begin
            if (bkReqQ) begin
               if (bk.bk_ack) begin
                  dirtyClr    = 1'b1;
                  dirtyClrIdx = walkIdx;
                  bkReqNext   = 1'b0;
                  walkAdv     = 1'b1;
               end
            end else if (valid[walkIdx] && dirty[walkIdx]) begin
               bkReqNext   = 1'b1;
               bkWeNext    = 1'b1;
               bkAddrNext  = {tagArr[walkIdx], walkIdx};
               bkWdataNext = dataArr[walkIdx];
            end else begin
               walkAdv = 1'b1;
            end
            if (walkAdv) begin
               if (&walkIdx) begin
                  stateNext     = IDLE;
                  flushDoneNext = 1'b1;
               end else begin
                  walkIdxNext = walkIdx + INDEX_W'(1);
               end
            end
         end
`endif
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         bkReqQ   <= 1'b0;
         bkWeQ    <= 1'b0;
         bkAddrQ  <= '0;
         bkWdataQ <= '0;
         valid    <= '0;
         dirty    <= '0;
`ifdef MEM_STAGE_CACHE_FLUSH_EN
         walkIdx    <= '0;
         flushDoneQ <= 1'b0;
`endif
      end else begin
         state    <= stateNext;
         bkReqQ   <= bkReqNext;
         bkWeQ    <= bkWeNext;
         bkAddrQ  <= bkAddrNext;
         bkWdataQ <= bkWdataNext;
         if (lineWe) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= lineDirty;
         end
         if (dirtyClr) dirty[dirtyClrIdx] <= 1'b0;
`ifdef MEM_STAGE_CACHE_FLUSH_EN
         walkIdx    <= walkIdxNext;
         flushDoneQ <= flushDoneNext;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (lineWe) begin
         tagArr[idx]  <= addrTag;
         dataArr[idx] <= lineData;
      end
   end

   mem_stage_cache_branch_resolve u_branch_resolve (
      .flags     (flags),
      .branch_op (branch_op),
      .saw_br    (saw_br),
      .saw_j     (saw_j),
      .pc_src    (pc_src)
   );

endmodule

// File: doc/mem_stage_cache.md
Name: mem_stage_cache

Overview:
- Parametrised next-generation MEM pipeline stage for the 16-bit core.
- Replaces the single-cycle data memory with a direct-mapped, write-back data cache of single-word lines with per-line dirty bits.
- The cache sits in front of a multi-cycle backing memory reached through a req/ack handshake, and stalls the pipeline on misses.
- Also owns branch resolution: flags + branch op -> pc_src.

Parameters:
- DATA_W, 16: data word width.
- ADDR_W, 16: word-address width.
- INDEX_W, 4: index bits; LINES = 2**INDEX_W; tag width = ADDR_W-INDEX_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_addr  in  ADDR_W  access word address; index = mem_addr[INDEX_W-1:0], tag = upper bits.
- wr_data  in  DATA_W  store data.
- mem_wr  in  1  store request.
- mem_rd  in  1  load request.
- flags  in  3  {N,Z,V} from EX.
- branch_op  in  3  branch condition code (BNEQ, BEQ, BGT, BLT, BGTE, BLTE, BOVFL, BUNCOND).
- saw_br  in  1  instruction is a conditional branch.
- saw_j  in  1  instruction is a jump.
- rd_data  out  DATA_W  load result.
- pc_src  out  1  take branch/jump.
- stall  out  1  freeze upstream pipeline; inputs held stable while high.
- bk_req  out  1  backing-memory request.
- bk_we  out  1  1 = write-back, 0 = fill.
- bk_addr  out  ADDR_W  backing word address.
- bk_wdata  out  DATA_W  write-back data.
- bk_rdata  in  DATA_W  fill data, valid with bk_ack.
- bk_ack  in  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE; all valid and dirty bits cleared. Dirty data is lost by design.
  - Outputs: bk_req=0, bk_we=0, bk_addr=0, bk_wdata=0, stall=0, rd_data=0.
  - Tag/data arrays are not reset.
- Access = mem_rd|mem_wr. If both are set, it is a write and mem_rd is ignored.
- hit = valid[idx] & tag[idx]==addr tag.
- rd_data is combinational from the data array at idx. It is valid when mem_rd & hit & state==IDLE; otherwise it holds the array value, and callers ignore it.
- States:
  - IDLE:
    - Read hit: 0-cycle, no stall.
    - Write hit: data written at the clock edge; dirty set; no stall.
    - Write miss, victim clean or invalid: install at the clock edge (tag, data, valid=1, dirty=1); no stall.
    - Any miss with victim valid & dirty: go to WB.
    - Read miss, victim clean: go to FILL.
  - WB:
    - bk_req=1, bk_we=1, bk_addr={victim tag, idx}, bk_wdata=victim data.
    - On bk_ack: clear dirty[idx], then go to FILL for a read or to IDLE for a write. The write miss then installs in IDLE on the following cycle.
  - FILL:
    - bk_req=1, bk_we=0, bk_addr=mem_addr.
    - On bk_ack: write bk_rdata, tag, valid=1, dirty=0; go to IDLE. The access then hits.
- stall = (state!=IDLE) | (state==IDLE & access & miss & (victim dirty | mem_rd)).
  - Stall drops the cycle after the final bk_ack.
- bk_req and all bk_* signals are registered, asserted from state entry and held stable until the bk_ack cycle. bk_req=0 the cycle after ack. bk_ack while bk_req=0 is ignored.
- Reset mid-transaction: bk_req drops immediately; the backing memory must abort the request.
- Branch logic, combinational, independent of stall:
  - cmp per branch_op:
    - BNEQ: !Z.
    - BEQ: Z.
    - BGT: !Z&!N.
    - BLT: N.
    - BGTE: !N.
    - BLTE: N|Z.
    - BOVFL: V.
    - BUNCOND: 1.
    - Other codes: 0.
  - pc_src = (saw_br & cmp) | saw_j.

Optional Feature:
- Macro: MEM_STAGE_CACHE_FLUSH_EN.
- Defined:
  - Adds input flush (1) and output flush_done (1, reset 0).
  - flush sampled in IDLE with no access starts state FLUSH: walks indices 0..LINES-1 in order, issues a WB handshake for each valid & dirty line, and skips clean lines at 1 cycle each.
  - stall=1 throughout; dirty cleared, valid retained.
  - flush_done pulses one cycle on completion, then returns to IDLE.
- Undefined: no ports, no FLUSH state, no walk counter.

Decomposition:
- Shared defines package: branch_op encodings (BNEQ..BUNCOND), flag bit positions N=2, Z=1, V=0, and FSM state encodings IDLE/WB/FILL/FLUSH.
- One natural sub-module, branch_resolve: combinational flags/branch_op/saw_br/saw_j -> pc_src.
- Tag/valid/dirty/data arrays stay inline.

Test Plan:
- Cold read miss: reset, INDEX_W=4, read 0x0010.
  - Required: stall=1; bk_req=1, bk_we=0, bk_addr=0x0010; bk_ack with 0xBEEF 3 cycles later.
  - Next cycle stall=0, rd_data=0xBEEF.
  - Repeat read: stall=0, no bk_req.
- Dirty eviction: write 0x1234 to 0x0010 (hit, no stall), then read 0x0110 (same index).
  - Required: WB with bk_we=1, bk_addr=0x0010, bk_wdata=0x1234, then FILL with bk_addr=0x0110.
  - rd_data = fill data; dirty[0]=0.
- Write miss, clean victim: write 0xAAAA to 0x0023.
  - Required: stall never asserts, no bk_req; later read 0x0023 returns 0xAAAA with no stall.
- Branch resolution:
  - flags=3'b100, BLT, saw_br=1 -> pc_src=1.
  - BGTE -> 0.
  - saw_br=0, saw_j=1 -> 1.
  - BOVFL with flags=3'b001 -> 1.
- Reset in FILL: assert rst_n=0 two cycles into FILL.
  - Required: bk_req=0 and stall=0 immediately.
  - After release, read of the same address misses again.
- FLUSH_EN: dirty lines at idx 2 and 5, pulse flush.
  - Required: two WBs in order idx2 then idx5; flush_done pulses once.
  - Subsequent reads of both lines hit with no bk traffic.
